reaction_timer: RTL and testbench
=================================

# reaction_timer

Consumes the 8-bit pseudo-random value from the lab's LFSR stage to run one round of a reaction-time test. It waits a random delay, lights an LED, and measures the user's response in milliseconds. It flags early presses and timeouts. The results feed the seven-segment display driver downstream.

## Interface
- `TICKS_PER_MS`, default 100000: clk cycles per millisecond (100 MHz board clock).
- `MIN_DELAY_MS`, default 1000: fixed part of the random delay.
- `MAX_MS`, default 9999: reaction count ceiling; reaching it raises timeout.
- `clk`  in  1: system clock, posedge. The LFSR updates on negedge, so `rnd` is stable at every posedge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: single-cycle pulse (debounced upstream); begins a round.
- `press`  in  1: single-cycle pulse (debounced upstream); user response.
- `rnd`  in  8: current LFSR output `q`.
- `led`  out  1: stimulus LED; high only in ARMED.
- `time_ms`  out  14: measured reaction time in ms.
- `done`  out  1: level; a valid measurement is held.
- `early`  out  1: level; press occurred before the LED lit.
- `timeout`  out  1: level; no press before `MAX_MS`.
- `busy`  out  1: high in WAIT or ARMED.

## Operation
States:
- IDLE: entered from reset.
  - `start` → WAIT.
  - `press` is ignored.
- WAIT:
  - On the entry edge, latch `delay_ms = MIN_DELAY_MS + {rnd, 3'b000}` (range MIN to MIN+2040).
  - On the entry edge, clear `time_ms`, `done`, `early`, `timeout`, and the prescaler.
  - Decrement `delay_ms` on each ms tick.
  - `press` → FAULT with `early` = 1.
  - Tick that makes `delay_ms` 0 → ARMED. The prescaler and `time_ms` are cleared.
- ARMED:
  - `led` = 1.
  - `time_ms` increments on each ms tick.
  - `press` → DONE with `done` = 1; `time_ms` is frozen.
  - `time_ms` reaching `MAX_MS` → FAULT with `timeout` = 1; `time_ms` holds `MAX_MS`.
- DONE / FAULT:
  - Outputs hold.
  - `start` → WAIT (new round, new `rnd` sample).
  - `press` is ignored.

Widths and arithmetic:
- `delay_ms` is 12 bits.
- `time_ms` is 14 bits, saturating at `MAX_MS` and never wrapping.
- Prescaler width is `$clog2(TICKS_PER_MS)`. It wraps at `TICKS_PER_MS-1` and emits a 1-cycle tick on that cycle.

Boundary rules:
- `start` during WAIT or ARMED is ignored; no restart.
- `press` and the final delay tick in the same cycle → FAULT/`early` (press wins).
- `press` and a ms tick in the same ARMED cycle → DONE. `time_ms` is NOT incremented on that cycle.
- `press` and `start` together in DONE/FAULT → WAIT (`start` wins).
- `rst` mid-round: immediate return to IDLE. All outputs reset, LED off.

## Timing
- Reset values: `led` = 0, `time_ms` = 0, `done` = 0, `early` = 0, `timeout` = 0, `busy` = 0; state IDLE; prescaler 0.
- All outputs are registered; there are no combinational paths from input to output.
- `start` accepted at edge k:
  - `busy` = 1 from k.
  - `led` rises exactly `delay_ms × TICKS_PER_MS` cycles after k.
- After `led` rises at edge a:
  - `time_ms` = n from edge a + n·`TICKS_PER_MS`.
- `press` at edge p:
  - `led` = 0, `busy` = 0, and `done`/`early` = 1 all take effect at edge p. There is one cycle of latency from the press sample.

## Structure
- Package `reaction_pkg`:
  - State enum: IDLE, WAIT, ARMED, DONE, FAULT.
  - Width constants `DELAY_W` = 12 and `TIME_W` = 14.
  - Shift amount constant `RND_SHIFT` = 3.
- Sub-module `ms_tick`: prescaler with a synchronous `clear` input and a `tick` output, parameterised by `TICKS_PER_MS`.
- The FSM and counters stay in `reaction_timer`.

## Test plan
All scenarios use `TICKS_PER_MS` = 4, `MIN_DELAY_MS` = 2, `MAX_MS` = 20.
- Reset, then `rnd` = 8'h03 and `start` → `busy` = 1; `led` rises 104 cycles later (26 ms); `press` 28 cycles after LED → `done` = 1, `time_ms` = 7, `led` = 0.
- `rnd` = 8'h00, `start`, `press` 5 cycles later → `early` = 1, `led` never rises, `busy` = 0.
- `rnd` = 8'h00, `start`, no `press` → `led` at cycle 8; `timeout` = 1 and `time_ms` = 20 at 80 cycles after LED; `time_ms` then holds.
- Second `start` mid-WAIT → ignored, LED timing unchanged. `start` after DONE → flags clear, new delay latched from current `rnd`.
- `press` coincident with a tick in ARMED at `time_ms` = 5 → `time_ms` stays 5, `done` = 1.
- `rst` asserted while ARMED → all outputs 0 asynchronously. After release, `press` is ignored until the next `start`.

Source files
------------

// File: rtl/reaction_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reaction_pkg : shared widths, shift amount and FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package reaction_pkg;

  localparam int DELAY_W   = 12;
  localparam int TIME_W    = 14;
  localparam int RND_SHIFT = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ARMED = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_e;

endpackage : reaction_pkg
`default_nettype wire

// File: rtl/ms_tick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ms_tick : millisecond prescaler, one-cycle tick on the terminal count
// Rev 1.0
// ---------------------------------------------------------------------------
module ms_tick #(
  parameter int TICKS_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_MS - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = (count_q == CNT_LAST);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : ms_tick
`default_nettype wire

// File: rtl/reaction_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reaction_timer : random delay, LED stimulus and ms reaction measurement
// Rev 1.0
// ---------------------------------------------------------------------------
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int TICKS_PER_MS = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = 9999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              press,
  input  logic [7:0]        rnd,
  output logic              led,
  output logic [TIME_W-1:0] time_ms,
  output logic              done,
  output logic              early,
  output logic              timeout,
  output logic              busy
);

  localparam logic [TIME_W-1:0]  TIME_MAX  = TIME_W'(MAX_MS);
  localparam logic [DELAY_W-1:0] DELAY_MIN = DELAY_W'(MIN_DELAY_MS);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [TIME_W-1:0]  time_inc;
  logic               done_q, done_d;
  logic               early_q, early_d;
  logic               timeout_q, timeout_d;
  logic               presc_clear;
  logic               ms_tick_w;

  ms_tick #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(presc_clear),
    .tick (ms_tick_w)
  );

  assign time_inc = time_q + TIME_W'(1);

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    time_d      = time_q;
    done_d      = done_q;
    early_d     = early_q;
    timeout_d   = timeout_q;
    presc_clear = 1'b0;

    case (state_q)
      WAIT: begin
        if (press) begin
          state_d = FAULT;
          early_d = 1'b1;
        end else if (ms_tick_w) begin
          // <= 1 also covers a zero-length delay so the round can never stall
          if (delay_q <= DELAY_W'(1)) begin
            state_d     = ARMED;
            delay_d     = '0;
            time_d      = '0;
            presc_clear = 1'b1;
          end else begin
            delay_d = delay_q - DELAY_W'(1);
          end
        end
      end
      ARMED: begin
        if (press) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (ms_tick_w) begin
          if (time_inc >= TIME_MAX) begin
            state_d   = FAULT;
            time_d    = TIME_MAX;
            timeout_d = 1'b1;
          end else begin
            time_d = time_inc;
          end
        end
      end
      IDLE, DONE, FAULT: begin
        if (start) begin
          state_d     = WAIT;
          delay_d     = DELAY_MIN + (DELAY_W'(rnd) << RND_SHIFT);
          time_d      = '0;
          done_d      = 1'b0;
          early_d     = 1'b0;
          timeout_d   = 1'b0;
          presc_clear = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      delay_q   <= '0;
      time_q    <= '0;
      done_q    <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      time_q    <= time_d;
      done_q    <= done_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
    end
  end

  assign led     = (state_q == ARMED);
  assign busy    = (state_q == WAIT) || (state_q == ARMED);
  assign time_ms = time_q;
  assign done    = done_q;
  assign early   = early_q;
  assign timeout = timeout_q;

endmodule : reaction_timer
`default_nettype wire

// File: tb/tb_reaction_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reaction_timer : directed rounds checked against a cycle-count model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_reaction_timer;

  localparam int T    = 4;
  localparam int MIND = 2;
  localparam int MAXT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        press;
  logic [7:0]  rnd;
  logic        led;
  logic [13:0] time_ms;
  logic        done;
  logic        early;
  logic        timeout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  reaction_timer #(
    .TICKS_PER_MS(T),
    .MIN_DELAY_MS(MIND),
    .MAX_MS      (MAXT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .press  (press),
    .rnd    (rnd),
    .led    (led),
    .time_ms(time_ms),
    .done   (done),
    .early  (early),
    .timeout(timeout),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting, 2 armed, 3 done, 4 fault.
  // Round timing is derived from the edge counts alone.
  int m_cyc = 0;
  int m_ph  = 0;
  int m_a   = 0;
  int m_tm  = 0;
  int m_done = 0, m_early = 0, m_to = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ph = 0; m_tm = 0; m_done = 0; m_early = 0; m_to = 0;
      end else begin
        m_cyc++;
        case (m_ph)
          1: begin
            if (press) begin m_ph = 4; m_early = 1; end
            else if (m_cyc == m_a) m_ph = 2;
          end
          2: begin
            if (press) begin
              m_ph = 3; m_done = 1; m_tm = (m_cyc - 1 - m_a) / T;
            end else if ((m_cyc - m_a) / T >= MAXT) begin
              m_ph = 4; m_to = 1; m_tm = MAXT;
            end else begin
              m_tm = (m_cyc - m_a) / T;
            end
          end
          default: begin
            if (start) begin
              m_ph = 1;
              m_a  = m_cyc + (MIND + int'(rnd) * 8) * T;
              m_tm = 0; m_done = 0; m_early = 0; m_to = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_led",     int'(led),     (m_ph == 2) ? 1 : 0);
      check("cyc_busy",    int'(busy),    (m_ph == 1 || m_ph == 2) ? 1 : 0);
      check("cyc_time",    int'(time_ms), m_tm);
      check("cyc_done",    int'(done),    m_done);
      check("cyc_early",   int'(early),   m_early);
      check("cyc_timeout", int'(timeout), m_to);
    end
  end

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int k);
    start = 1'b1;
    tick_edge();
    start = 1'b0;
    k = edge_n;
  endtask

  task automatic pulse_press();
    press = 1'b1;
    tick_edge();
    press = 1'b0;
  endtask

  task automatic wait_led(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      tick_edge();
      if (led === 1'b1) begin
        at = edge_n;
        break;
      end
    end
    if (at < 0) check("led_wait_bound", 0, 1);
  endtask

  task automatic wait_timeout(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      tick_edge();
      if (timeout === 1'b1) begin
        at = edge_n;
        break;
      end
    end
    if (at < 0) check("timeout_wait_bound", 0, 1);
  endtask

  int k, k2, a, t;
  int led_seen;

  initial begin
    rst = 1'b1; start = 1'b0; press = 1'b0; rnd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_time", int'(time_ms), 0);
    rst = 1'b0;
    tick_edge();

    // Round 1: rnd=3 -> 26 ms delay, press reported at 7 ms
    rnd = 8'h03;
    pulse_start(k);
    check("r1_busy", int'(busy), 1);
    wait_led(300, a);
    check("r1_led_delay", a - k, 104);
    repeat (28) tick_edge();
    pulse_press();
    check("r1_done", int'(done), 1);
    check("r1_time", int'(time_ms), 7);
    check("r1_led_off", int'(led), 0);

    // Round 2: early press, LED never lights
    rnd = 8'h00;
    pulse_start(k);
    repeat (4) tick_edge();
    pulse_press();
    check("r2_early", int'(early), 1);
    check("r2_busy", int'(busy), 0);
    led_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick_edge();
      if (led === 1'b1) led_seen = 1;
    end
    check("r2_led_never", led_seen, 0);

    // Round 3: no press, saturate at MAX_MS
    pulse_start(k);
    wait_led(100, a);
    check("r3_led_delay", a - k, 8);
    wait_timeout(200, t);
    check("r3_timeout_at", t - a, 80);
    check("r3_time_max", int'(time_ms), 20);
    repeat (10) tick_edge();
    check("r3_time_hold", int'(time_ms), 20);

    // Round 4: restart during WAIT ignored; press coincident with a tick
    rnd = 8'h03;
    pulse_start(k);
    repeat (10) tick_edge();
    rnd = 8'h10;
    pulse_start(k2);
    wait_led(300, a);
    check("r4_led_delay", a - k, 104);
    repeat (23) tick_edge();
    pulse_press();
    check("r4_time_coinc", int'(time_ms), 5);
    check("r4_done", int'(done), 1);

    // Round 5: new start after DONE samples current rnd
    rnd = 8'h01;
    pulse_start(k);
    check("r5_done_clr", int'(done), 0);
    check("r5_busy", int'(busy), 1);
    wait_led(200, a);
    check("r5_led_delay", a - k, 40);

    // Asynchronous reset while ARMED
    repeat (6) tick_edge();
    #3 rst = 1'b1;
    #1;
    check("ar_led", int'(led), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_time", int'(time_ms), 0);
    @(negedge clk);
    rst = 1'b0;
    tick_edge();
    pulse_press();
    repeat (5) tick_edge();
    check("ar_press_busy", int'(busy), 0);
    check("ar_press_done", int'(done), 0);
    check("ar_press_early", int'(early), 0);
    rnd = 8'h00;
    pulse_start(k);
    wait_led(100, a);
    check("ar_led_delay", a - k, 8);

    repeat (3) tick_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got %0d expected %0d", 0, 1);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reaction_timer
`default_nettype wire
